rs_age: RTL and testbench
=========================

RS_AGE -- requirements
Module: rs_age

Interface
REQ-001 Parameter RS_DEPTH, default 16: number of entries, at least 2; all entries usable, no reserved slot.
REQ-002 Parameter ROB_W, default 4: tag width; tag 0 means "operand available".
REQ-003 Parameter DATA_W, default 32: operand, immediate and pc width.
REQ-004 Parameter OP_W, default 6: operator code width.
REQ-005 Parameter CDB_N, default 2: number of broadcast channels.
REQ-006 in_clk  input  1  sole clock; all state on rising edge.
REQ-007 in_rst  input  1  reset, synchronous, active-high.
REQ-008 in_rdy  input  1  global enable; low freezes all state.
REQ-009 in_flush  input  1  discard all entries and pending issue.
REQ-010 in_alloc_valid  input  1  allocate one instruction this cycle.
REQ-011 in_alloc_type/imm/pc  input  OP_W/DATA_W/DATA_W  instruction fields.
REQ-012 in_alloc_qj, in_alloc_qk, in_alloc_dest  input  ROB_W each  source tags and destination tag.
REQ-013 in_alloc_vj, in_alloc_vk  input  DATA_W each  source values, valid when the matching tag is 0.
REQ-014 in_cdb_valid  input  CDB_N  per-channel broadcast strobe.
REQ-015 in_cdb_tag  input  CDB_N*ROB_W  packed tags; channel c occupies bits [c*ROB_W +: ROB_W].
REQ-016 in_cdb_data  input  CDB_N*DATA_W  packed results, same packing.
REQ-017 out_full  output  1  no free entry (combinational from state).
REQ-018 out_count  output  clog2(RS_DEPTH)+1  busy entry count, registered.
REQ-019 out_issue_valid  output  1  issue register holds an instruction.
REQ-020 in_issue_ready  input  1  consumer accepts the issue register this cycle.
REQ-021 out_issue_type/pc/imm/vj/vk/dest  output  OP_W/DATA_W x4/ROB_W  registered issue payload.

Function
REQ-022 Allocation: when in_alloc_valid and !out_full, the lowest-index free entry SHALL become busy at the edge; when out_full, the request SHALL be dropped with no state change.
REQ-023 Wakeup: for each busy entry and each operand with nonzero tag equal to a valid CDB tag, set tag to 0 and capture data; if several channels match, the lowest channel index SHALL win.
REQ-024 Bypass: an allocating instruction whose qj or qk matches a same-cycle valid CDB tag SHALL be stored with tag 0 and the broadcast data.
REQ-025 CDB tag 0 SHALL never wake anything.
REQ-026 Ready: entry busy, qj==0 and qk==0, evaluated on registered state; wakeups and allocations become eligible the cycle after their edge (minimum alloc-to-issue-valid latency 1 cycle).
REQ-027 Selection: among ready entries, the oldest by allocation order SHALL issue; ordering is exact across wrap and free-slot reuse; ties are impossible.
REQ-028 Issue load: when (!out_issue_valid or in_issue_ready) and a ready entry exists, load payload into issue register, set out_issue_valid, free the entry at the same edge.
REQ-029 Backpressure: while out_issue_valid and !in_issue_ready, issue register and all entry busy bits SHALL hold; wakeup and allocation continue.
REQ-030 Accept without refill: in_issue_ready with no ready entry SHALL clear out_issue_valid.
REQ-031 A slot freed by issue SHALL NOT be reallocated in the same cycle; out_full is based on pre-edge state.
REQ-032 out_count next = count + alloc_accepted - issued, exact when both occur together.
REQ-033 in_flush (with in_rdy) SHALL clear all busy bits, out_issue_valid, age state and out_count at the edge, overriding same-cycle allocation, wakeup and issue.
REQ-034 in_rdy low SHALL suppress allocation, wakeup, issue and flush; outputs hold.

Reset
REQ-035 in_rst high at an edge SHALL clear all busy bits, out_issue_valid=0, out_count=0, age state cleared, regardless of in_rdy; payload registers are don't-care.
REQ-036 Reset mid-operation SHALL discard entries and the pending issue; out_full=0 in the cycle after reset.

Verification
REQ-037 Fill/full: 16 allocations with qj=qk=3 -> out_full=1, out_count=16; 17th request dropped; CDB tag 3 data 0x55 -> next 16 issues, oldest first, vj=vk=0x55.
REQ-038 Age order: allocate A(dest 1, qj=5), B(dest 2, qj=6); broadcast tag 6 then tag 5 one cycle apart -> issues dest 2 then dest 1; then with both ready in the same cycle, the older issues first.
REQ-039 Bypass/dual CDB: allocate qj=7,qk=8 while ch0 tag 7 = 0x11 and ch1 tag 8 = 0x22 -> issue next cycle with vj=0x11, vk=0x22; both channels tag 9 with different data -> ch0 data captured.
REQ-040 Backpressure: hold in_issue_ready=0 for 5 cycles with 3 ready entries -> payload stable, out_count unchanged; ready=1 -> one issue per cycle.
REQ-041 Flush: 6 busy entries, issue pending, alloc_valid asserted with in_flush -> next cycle out_count=0, out_issue_valid=0, out_full=0.
REQ-042 in_rdy/reset: in_rdy=0 with alloc and CDB active -> no change; in_rst=1 with in_rdy=0 -> all cleared.

Source files
------------

// File: rtl/rs_age.sv
// Reservation station with CDB wakeup, same-cycle bypass and oldest-ready issue.
// Allocation age is tracked with a pairwise "older-than" matrix so ordering stays exact under slot reuse.
module rs_age #(
  parameter int RS_DEPTH = 16,
  parameter int ROB_W    = 4,
  parameter int DATA_W   = 32,
  parameter int OP_W     = 6,
  parameter int CDB_N    = 2
) (
  input  logic                      in_clk,
  input  logic                      in_rst,
  input  logic                      in_rdy,
  input  logic                      in_flush,
  input  logic                      in_alloc_valid,
  input  logic [OP_W-1:0]           in_alloc_type,
  input  logic [DATA_W-1:0]         in_alloc_imm,
  input  logic [DATA_W-1:0]         in_alloc_pc,
  input  logic [ROB_W-1:0]          in_alloc_qj,
  input  logic [ROB_W-1:0]          in_alloc_qk,
  input  logic [ROB_W-1:0]          in_alloc_dest,
  input  logic [DATA_W-1:0]         in_alloc_vj,
  input  logic [DATA_W-1:0]         in_alloc_vk,
  input  logic [CDB_N-1:0]          in_cdb_valid,
  input  logic [CDB_N*ROB_W-1:0]    in_cdb_tag,
  input  logic [CDB_N*DATA_W-1:0]   in_cdb_data,
  output logic                      out_full,
  output logic [$clog2(RS_DEPTH):0] out_count,
  output logic                      out_issue_valid,
  input  logic                      in_issue_ready,
  output logic [OP_W-1:0]           out_issue_type,
  output logic [DATA_W-1:0]         out_issue_pc,
  output logic [DATA_W-1:0]         out_issue_imm,
  output logic [DATA_W-1:0]         out_issue_vj,
  output logic [DATA_W-1:0]         out_issue_vk,
  output logic [ROB_W-1:0]          out_issue_dest
);

  localparam int IDX_W = $clog2(RS_DEPTH);
  localparam int CNT_W = $clog2(RS_DEPTH) + 1;

  logic [RS_DEPTH-1:0] busy_q, busy_d;
  logic [OP_W-1:0]     type_q [RS_DEPTH];
  logic [OP_W-1:0]     type_d [RS_DEPTH];
  logic [DATA_W-1:0]   pc_q   [RS_DEPTH];
  logic [DATA_W-1:0]   pc_d   [RS_DEPTH];
  logic [DATA_W-1:0]   imm_q  [RS_DEPTH];
  logic [DATA_W-1:0]   imm_d  [RS_DEPTH];
  logic [DATA_W-1:0]   vj_q   [RS_DEPTH];
  logic [DATA_W-1:0]   vj_d   [RS_DEPTH];
  logic [DATA_W-1:0]   vk_q   [RS_DEPTH];
  logic [DATA_W-1:0]   vk_d   [RS_DEPTH];
  logic [ROB_W-1:0]    qj_q   [RS_DEPTH];
  logic [ROB_W-1:0]    qj_d   [RS_DEPTH];
  logic [ROB_W-1:0]    qk_q   [RS_DEPTH];
  logic [ROB_W-1:0]    qk_d   [RS_DEPTH];
  logic [ROB_W-1:0]    dest_q [RS_DEPTH];
  logic [ROB_W-1:0]    dest_d [RS_DEPTH];
  // older_q[i][j] set means entry i was allocated before entry j
  logic [RS_DEPTH-1:0] older_q [RS_DEPTH];
  logic [RS_DEPTH-1:0] older_d [RS_DEPTH];

  logic [CNT_W-1:0]    count_q, count_d;
  logic                iss_valid_q, iss_valid_d;
  logic [OP_W-1:0]     iss_type_q, iss_type_d;
  logic [DATA_W-1:0]   iss_pc_q, iss_pc_d;
  logic [DATA_W-1:0]   iss_imm_q, iss_imm_d;
  logic [DATA_W-1:0]   iss_vj_q, iss_vj_d;
  logic [DATA_W-1:0]   iss_vk_q, iss_vk_d;
  logic [ROB_W-1:0]    iss_dest_q, iss_dest_d;

  logic [RS_DEPTH-1:0] ready_s;
  logic [RS_DEPTH-1:0] older_col_s;
  logic [IDX_W-1:0]    sel_idx_s;
  logic                any_ready_s;
  logic [IDX_W-1:0]    free_idx_s;
  logic                alloc_fire_s;
  logic                issue_fire_s;
  logic [DATA_W:0]     hit_j_s;
  logic [DATA_W:0]     hit_k_s;

  // {hit, data}: iterating high-to-low lets the lowest matching channel win; tag 0 never matches
  function automatic logic [DATA_W:0] cdb_lookup(
    input logic [ROB_W-1:0]        tag,
    input logic [CDB_N-1:0]        valid,
    input logic [CDB_N*ROB_W-1:0]  tags,
    input logic [CDB_N*DATA_W-1:0] data
  );
    logic [DATA_W:0] r;
    r = '0;
    for (int c = CDB_N - 1; c >= 0; c--) begin
      if (valid[c] && (tag != '0) && (tags[c*ROB_W +: ROB_W] == tag)) begin
        r = {1'b1, data[c*DATA_W +: DATA_W]};
      end
    end
    return r;
  endfunction

  assign out_full        = &busy_q;
  assign out_count       = count_q;
  assign out_issue_valid = iss_valid_q;
  assign out_issue_type  = iss_type_q;
  assign out_issue_pc    = iss_pc_q;
  assign out_issue_imm   = iss_imm_q;
  assign out_issue_vj    = iss_vj_q;
  assign out_issue_vk    = iss_vk_q;
  assign out_issue_dest  = iss_dest_q;

  // A ready entry is selected when no other ready entry is older than it
  always_comb begin
    ready_s     = '0;
    older_col_s = '0;
    sel_idx_s   = '0;
    any_ready_s = 1'b0;
    for (int i = 0; i < RS_DEPTH; i++) begin
      ready_s[i] = busy_q[i] && (qj_q[i] == '0) && (qk_q[i] == '0);
    end
    for (int i = 0; i < RS_DEPTH; i++) begin
      for (int j = 0; j < RS_DEPTH; j++) begin
        older_col_s[j] = older_q[j][i];
      end
      if (ready_s[i] && ((ready_s & older_col_s) == '0)) begin
        sel_idx_s   = IDX_W'(i);
        any_ready_s = 1'b1;
      end
    end
  end

  always_comb begin
    free_idx_s = '0;
    for (int i = RS_DEPTH - 1; i >= 0; i--) begin
      if (!busy_q[i]) begin
        free_idx_s = IDX_W'(i);
      end
    end
  end

  always_comb begin
    busy_d       = busy_q;
    type_d       = type_q;
    pc_d         = pc_q;
    imm_d        = imm_q;
    vj_d         = vj_q;
    vk_d         = vk_q;
    qj_d         = qj_q;
    qk_d         = qk_q;
    dest_d       = dest_q;
    older_d      = older_q;
    count_d      = count_q;
    iss_valid_d  = iss_valid_q;
    iss_type_d   = iss_type_q;
    iss_pc_d     = iss_pc_q;
    iss_imm_d    = iss_imm_q;
    iss_vj_d     = iss_vj_q;
    iss_vk_d     = iss_vk_q;
    iss_dest_d   = iss_dest_q;
    alloc_fire_s = 1'b0;
    issue_fire_s = 1'b0;
    hit_j_s      = '0;
    hit_k_s      = '0;
    if (in_rdy && in_flush) begin
      busy_d      = '0;
      iss_valid_d = 1'b0;
      count_d     = '0;
      for (int i = 0; i < RS_DEPTH; i++) begin
        older_d[i] = '0;
      end
    end else if (in_rdy) begin
      for (int i = 0; i < RS_DEPTH; i++) begin
        if (busy_q[i]) begin
          hit_j_s = cdb_lookup(qj_q[i], in_cdb_valid, in_cdb_tag, in_cdb_data);
          hit_k_s = cdb_lookup(qk_q[i], in_cdb_valid, in_cdb_tag, in_cdb_data);
          if (hit_j_s[DATA_W]) begin
            qj_d[i] = '0;
            vj_d[i] = hit_j_s[DATA_W-1:0];
          end
          if (hit_k_s[DATA_W]) begin
            qk_d[i] = '0;
            vk_d[i] = hit_k_s[DATA_W-1:0];
          end
        end
      end
      // Under backpressure the issue register and busy bits hold
      if (!iss_valid_q || in_issue_ready) begin
        if (any_ready_s) begin
          issue_fire_s      = 1'b1;
          iss_valid_d       = 1'b1;
          iss_type_d        = type_q[sel_idx_s];
          iss_pc_d          = pc_q[sel_idx_s];
          iss_imm_d         = imm_q[sel_idx_s];
          iss_vj_d          = vj_q[sel_idx_s];
          iss_vk_d          = vk_q[sel_idx_s];
          iss_dest_d        = dest_q[sel_idx_s];
          busy_d[sel_idx_s] = 1'b0;
        end else begin
          iss_valid_d = 1'b0;
        end
      end
      // free_idx_s comes from pre-edge busy bits, so a slot freed by this issue is not reused now
      if (in_alloc_valid && !out_full) begin
        alloc_fire_s         = 1'b1;
        busy_d[free_idx_s]   = 1'b1;
        type_d[free_idx_s]   = in_alloc_type;
        pc_d[free_idx_s]     = in_alloc_pc;
        imm_d[free_idx_s]    = in_alloc_imm;
        dest_d[free_idx_s]   = in_alloc_dest;
        hit_j_s = cdb_lookup(in_alloc_qj, in_cdb_valid, in_cdb_tag, in_cdb_data);
        hit_k_s = cdb_lookup(in_alloc_qk, in_cdb_valid, in_cdb_tag, in_cdb_data);
        qj_d[free_idx_s] = hit_j_s[DATA_W] ? '0 : in_alloc_qj;
        vj_d[free_idx_s] = hit_j_s[DATA_W] ? hit_j_s[DATA_W-1:0] : in_alloc_vj;
        qk_d[free_idx_s] = hit_k_s[DATA_W] ? '0 : in_alloc_qk;
        vk_d[free_idx_s] = hit_k_s[DATA_W] ? hit_k_s[DATA_W-1:0] : in_alloc_vk;
        older_d[free_idx_s] = '0;
        for (int j = 0; j < RS_DEPTH; j++) begin
          if (j != int'(free_idx_s)) begin
            older_d[j][free_idx_s] = 1'b1;
          end
        end
      end
      count_d = count_q + CNT_W'(alloc_fire_s) - CNT_W'(issue_fire_s);
    end
  end

  always_ff @(posedge in_clk) begin
    if (in_rst) begin
      busy_q      <= '0;
      count_q     <= '0;
      iss_valid_q <= 1'b0;
      for (int i = 0; i < RS_DEPTH; i++) begin
        older_q[i] <= '0;
      end
    end else begin
      busy_q      <= busy_d;
      type_q      <= type_d;
      pc_q        <= pc_d;
      imm_q       <= imm_d;
      vj_q        <= vj_d;
      vk_q        <= vk_d;
      qj_q        <= qj_d;
      qk_q        <= qk_d;
      dest_q      <= dest_d;
      older_q     <= older_d;
      count_q     <= count_d;
      iss_valid_q <= iss_valid_d;
      iss_type_q  <= iss_type_d;
      iss_pc_q    <= iss_pc_d;
      iss_imm_q   <= iss_imm_d;
      iss_vj_q    <= iss_vj_d;
      iss_vk_q    <= iss_vk_d;
      iss_dest_q  <= iss_dest_d;
    end
  end

endmodule

// File: tb/tb_rs_age.sv
// Directed bench for rs_age: an age-ordered queue model is checked every cycle,
// plus literal expectations from hand-worked scenarios.
module tb_rs_age;
  logic        clk = 1'b0;
  logic        rst, rdy, flush, alloc_valid, issue_ready;
  logic [5:0]  alloc_type;
  logic [31:0] alloc_imm, alloc_pc, alloc_vj, alloc_vk;
  logic [3:0]  alloc_qj, alloc_qk, alloc_dest;
  logic [1:0]  cdb_valid;
  logic [7:0]  cdb_tag;
  logic [63:0] cdb_data;
  logic        full, iss_valid;
  logic [4:0]  count;
  logic [5:0]  iss_type;
  logic [31:0] iss_pc, iss_imm, iss_vj, iss_vk;
  logic [3:0]  iss_dest;

  int checks = 0;
  int failures = 0;
  bit started = 1'b0;

  rs_age dut (
    .in_clk(clk), .in_rst(rst), .in_rdy(rdy), .in_flush(flush),
    .in_alloc_valid(alloc_valid), .in_alloc_type(alloc_type), .in_alloc_imm(alloc_imm),
    .in_alloc_pc(alloc_pc), .in_alloc_qj(alloc_qj), .in_alloc_qk(alloc_qk),
    .in_alloc_dest(alloc_dest), .in_alloc_vj(alloc_vj), .in_alloc_vk(alloc_vk),
    .in_cdb_valid(cdb_valid), .in_cdb_tag(cdb_tag), .in_cdb_data(cdb_data),
    .out_full(full), .out_count(count), .out_issue_valid(iss_valid),
    .in_issue_ready(issue_ready), .out_issue_type(iss_type), .out_issue_pc(iss_pc),
    .out_issue_imm(iss_imm), .out_issue_vj(iss_vj), .out_issue_vk(iss_vk),
    .out_issue_dest(iss_dest)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: busy entries kept as a queue in allocation order, so the oldest ready is the first ready
  typedef struct {
    logic [5:0]  typ;
    logic [31:0] pc, imm, vj, vk;
    logic [3:0]  dest, qj, qk;
  } ent_t;
  ent_t mq[$];
  ent_t miss;
  bit   miv = 1'b0;

  function automatic void wake(input logic [3:0] tin, input logic [31:0] vin,
                               output logic [3:0] tout, output logic [31:0] vout);
    tout = tin;
    vout = vin;
    for (int c = 0; c < 2; c++) begin
      if (tout != 4'd0 && cdb_valid[c] && cdb_tag[c*4 +: 4] == tout) begin
        vout = cdb_data[c*32 +: 32];
        tout = 4'd0;
      end
    end
  endfunction

  always @(posedge clk) begin
    ent_t e;
    int   f;
    bit   pre_full;
    if (rst) begin
      mq.delete();
      miv = 1'b0;
    end else if (rdy && flush) begin
      mq.delete();
      miv = 1'b0;
    end else if (rdy) begin
      pre_full = (mq.size() == 16);
      if (!miv || issue_ready) begin
        f = -1;
        for (int i = 0; i < mq.size(); i++) begin
          if (f < 0 && mq[i].qj == 4'd0 && mq[i].qk == 4'd0) f = i;
        end
        if (f >= 0) begin
          miss = mq[f];
          miv  = 1'b1;
          mq.delete(f);
        end else begin
          miv = 1'b0;
        end
      end
      for (int i = 0; i < mq.size(); i++) begin
        e = mq[i];
        wake(e.qj, e.vj, e.qj, e.vj);
        wake(e.qk, e.vk, e.qk, e.vk);
        mq[i] = e;
      end
      if (alloc_valid && !pre_full) begin
        e.typ = alloc_type; e.pc = alloc_pc; e.imm = alloc_imm; e.dest = alloc_dest;
        wake(alloc_qj, alloc_vj, e.qj, e.vj);
        wake(alloc_qk, alloc_vk, e.qk, e.vk);
        mq.push_back(e);
      end
    end
  end

  always @(negedge clk) begin
    if (started) begin
      check("m_count", 64'(count), 64'(mq.size()));
      check("m_full", 64'(full), 64'(mq.size() == 16));
      check("m_iss_valid", 64'(iss_valid), 64'(miv));
      if (miv) begin
        check("m_type", 64'(iss_type), 64'(miss.typ));
        check("m_pc", 64'(iss_pc), 64'(miss.pc));
        check("m_imm", 64'(iss_imm), 64'(miss.imm));
        check("m_vj", 64'(iss_vj), 64'(miss.vj));
        check("m_vk", 64'(iss_vk), 64'(miss.vk));
        check("m_dest", 64'(iss_dest), 64'(miss.dest));
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  task automatic idle();
    alloc_valid = 1'b0; cdb_valid = 2'b00; flush = 1'b0;
  endtask

  task automatic set_alloc(input logic [3:0] dest, input logic [3:0] qj, input logic [3:0] qk,
                           input logic [31:0] vj, input logic [31:0] vk, input logic [31:0] pc);
    alloc_valid = 1'b1; alloc_dest = dest; alloc_qj = qj; alloc_qk = qk;
    alloc_vj = vj; alloc_vk = vk; alloc_pc = pc;
    alloc_type = pc[5:0]; alloc_imm = pc ^ 32'hA5A5_0000;
  endtask

  task automatic set_cdb(input logic [1:0] v, input logic [3:0] t0, input logic [3:0] t1,
                         input logic [31:0] d0, input logic [31:0] d1);
    cdb_valid = v; cdb_tag = {t1, t0}; cdb_data = {d1, d0};
  endtask

  initial begin
    rst = 1'b1; rdy = 1'b1; issue_ready = 1'b1;
    idle();
    set_alloc(4'd0, 4'd0, 4'd0, 32'd0, 32'd0, 32'd0);
    alloc_valid = 1'b0;
    set_cdb(2'b00, 4'd0, 4'd0, 32'd0, 32'd0);
    cyc(); cyc();
    rst = 1'b0;
    started = 1'b1;
    check("rst_count", 64'(count), 64'd0);
    check("rst_full", 64'(full), 64'd0);
    check("rst_iss_valid", 64'(iss_valid), 64'd0);

    // Fill to full, drop the 17th, then wake all and drain oldest first
    for (int i = 0; i < 16; i++) begin
      set_alloc(4'(i), 4'd3, 4'd3, 32'd0, 32'd0, 32'h100 + 32'(i));
      cyc();
    end
    check("fill_count", 64'(count), 64'd16);
    check("fill_full", 64'(full), 64'd1);
    set_alloc(4'd15, 4'd0, 4'd0, 32'd1, 32'd1, 32'h999);
    cyc();
    check("drop_count", 64'(count), 64'd16);
    idle();
    set_cdb(2'b01, 4'd3, 4'd0, 32'h55, 32'd0);
    cyc();
    idle();
    cyc();
    for (int k = 0; k < 16; k++) begin
      check("fill_pc", 64'(iss_pc), 64'h100 + 64'(k));
      check("fill_vj", 64'(iss_vj), 64'h55);
      cyc();
    end
    check("fill_drained", 64'(iss_valid), 64'd0);

    // Age order: younger woken first issues first; then two ready together, older in higher slot
    set_alloc(4'd1, 4'd5, 4'd0, 32'd0, 32'h1, 32'hA0); cyc();
    set_alloc(4'd2, 4'd6, 4'd0, 32'd0, 32'h2, 32'hB0); cyc();
    idle(); set_cdb(2'b01, 4'd6, 4'd0, 32'h66, 32'd0); cyc();
    set_cdb(2'b01, 4'd5, 4'd0, 32'h77, 32'd0); cyc();
    check("age_first", 64'(iss_dest), 64'd2);
    idle(); cyc();
    check("age_second", 64'(iss_dest), 64'd1);
    check("age_vj", 64'(iss_vj), 64'h77);
    cyc();
    set_alloc(4'd6, 4'd0, 4'd0, 32'h6, 32'h6, 32'hC0); cyc();
    set_alloc(4'd3, 4'd10, 4'd0, 32'd0, 32'h3, 32'hC1); cyc();
    check("reuse_issue", 64'(iss_dest), 64'd6);
    set_alloc(4'd4, 4'd10, 4'd0, 32'd0, 32'h4, 32'hC2); cyc();
    idle(); set_cdb(2'b01, 4'd10, 4'd0, 32'hAB, 32'd0); cyc();
    idle(); cyc();
    check("tie_older", 64'(iss_dest), 64'd3);
    cyc();
    check("tie_younger", 64'(iss_dest), 64'd4);
    cyc();

    // Bypass on both channels, then both channels carry the same tag
    set_alloc(4'd7, 4'd7, 4'd8, 32'hDEAD, 32'hDEAD, 32'hD0);
    set_cdb(2'b11, 4'd7, 4'd8, 32'h11, 32'h22);
    cyc();
    idle(); cyc();
    check("byp_valid", 64'(iss_valid), 64'd1);
    check("byp_vj", 64'(iss_vj), 64'h11);
    check("byp_vk", 64'(iss_vk), 64'h22);
    cyc();
    set_alloc(4'd9, 4'd9, 4'd0, 32'd0, 32'h33, 32'hD1); cyc();
    idle(); set_cdb(2'b11, 4'd9, 4'd9, 32'hAA, 32'hBB); cyc();
    idle(); cyc();
    check("dual_vj", 64'(iss_vj), 64'hAA);
    check("dual_vk", 64'(iss_vk), 64'h33);
    cyc();

    // Backpressure holds the issue register; release drains one per cycle
    issue_ready = 1'b0;
    set_alloc(4'd1, 4'd0, 4'd0, 32'h101, 32'd0, 32'hE0); cyc();
    set_alloc(4'd2, 4'd0, 4'd0, 32'h102, 32'd0, 32'hE1); cyc();
    set_alloc(4'd3, 4'd0, 4'd0, 32'h103, 32'd0, 32'hE2); cyc();
    idle();
    for (int i = 0; i < 5; i++) begin
      cyc();
      check("bp_dest", 64'(iss_dest), 64'd1);
      check("bp_count", 64'(count), 64'd2);
    end
    issue_ready = 1'b1;
    cyc();
    check("bp_rel1", 64'(iss_dest), 64'd2);
    cyc();
    check("bp_rel2", 64'(iss_dest), 64'd3);
    cyc();
    check("bp_empty", 64'(iss_valid), 64'd0);

    // Flush with a pending issue and a same-cycle allocation
    issue_ready = 1'b0;
    set_alloc(4'd7, 4'd0, 4'd0, 32'h7, 32'h7, 32'hF0); cyc();
    for (int i = 0; i < 6; i++) begin
      set_alloc(4'(i), 4'd13, 4'd0, 32'd0, 32'd0, 32'hF1 + 32'(i)); cyc();
    end
    check("pre_flush_count", 64'(count), 64'd6);
    flush = 1'b1;
    cyc();
    check("flush_count", 64'(count), 64'd0);
    check("flush_iss_valid", 64'(iss_valid), 64'd0);
    check("flush_full", 64'(full), 64'd0);
    idle(); issue_ready = 1'b1;
    cyc();

    // Enable low freezes; reset with enable low still clears
    set_alloc(4'd1, 4'd14, 4'd0, 32'd0, 32'd0, 32'h200); cyc();
    set_alloc(4'd2, 4'd14, 4'd0, 32'd0, 32'd0, 32'h201); cyc();
    rdy = 1'b0;
    set_alloc(4'd3, 4'd0, 4'd0, 32'd0, 32'd0, 32'h202);
    set_cdb(2'b01, 4'd14, 4'd0, 32'h99, 32'd0);
    cyc(); cyc(); cyc();
    check("rdy_count", 64'(count), 64'd2);
    check("rdy_iss", 64'(iss_valid), 64'd0);
    idle(); rdy = 1'b1;
    cyc();
    check("rdy_nowake", 64'(iss_valid), 64'd0);
    rdy = 1'b0; rst = 1'b1;
    cyc();
    check("rst2_count", 64'(count), 64'd0);
    check("rst2_full", 64'(full), 64'd0);
    rst = 1'b0; rdy = 1'b1;
    cyc();
    check("post_rst_count", 64'(count), 64'd0);
    cyc();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
